// File: rtl/result_formatter.sv
// result_formatter: buffers signed 18-bit words in a FIFO and prints them as decimal ASCII text,
// space-separated with a newline every VALUES_PER_LINE values.
module result_formatter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int VALUES_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] read_data,
  input  logic        read_valid,
  output logic [7:0]  print_char,
  output logic        print_valid,
  input  logic        print_ready,
  output logic        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, SIGN, DIV, EMIT, SEP} state_t;
  state_t      state;
  logic [17:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [17:0] value, mag, pw;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic        lz;
  logic [15:0] line;
  logic        full, push, pop, xfer, skip, last;
  always_comb begin
    full = cnt == (AW+1)'(FIFO_DEPTH);
    push = read_valid && !full;
    pop  = state == IDLE && cnt != '0;
    xfer = print_valid && print_ready;
    skip = digit == 4'd0 && lz && idx != 3'd0;
    last = line == 16'(VALUES_PER_LINE - 1);
    pw   = idx == 3'd5 ? 18'd100000 : idx == 3'd4 ? 18'd10000 : idx == 3'd3 ? 18'd1000 :
           idx == 3'd2 ? 18'd100 : idx == 3'd1 ? 18'd10 : 18'd1;
  end
  // a push against a full FIFO is dropped even if a pop happens in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wp] <= read_data;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (read_valid && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      print_valid <= 1'b0;
      print_char  <= 8'h00;
      line        <= '0;
      digit       <= '0;
      value       <= '0;
      mag         <= '0;
      idx         <= '0;
      lz          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          value <= mem[rp];
          state <= LOAD;
        end
        LOAD: begin
          mag   <= value[17] ? -value : value;
          idx   <= 3'd5;
          lz    <= 1'b1;
          digit <= '0;
          if (value[17]) begin
            print_char  <= 8'h2D;
            print_valid <= 1'b1;
            state       <= SIGN;
          end else state <= DIV;
        end
        SIGN: if (xfer) begin
          print_valid <= 1'b0;
          state       <= DIV;
        end
        DIV: if (mag >= pw) begin
          mag   <= mag - pw;
          digit <= digit + 4'd1;
        end else begin
          state <= EMIT;
          if (!skip) begin
            print_char  <= 8'h30 + {4'd0, digit};
            print_valid <= 1'b1;
            lz          <= 1'b0;
          end
        end
        // an EMIT entered without a presented character is a suppressed leading zero
        EMIT: if (!print_valid) begin
          idx   <= idx - 3'd1;
          state <= DIV;
        end else if (xfer) begin
          digit <= '0;
          if (idx == 3'd0) begin
            print_char <= last ? 8'h0A : 8'h20;
            state      <= SEP;
          end else begin
            print_valid <= 1'b0;
            idx         <= idx - 3'd1;
            state       <= DIV;
          end
        end
        SEP: if (xfer) begin
          print_valid <= 1'b0;
          line        <= last ? '0 : line + 16'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
